// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes and the bridge FSM state enum.
// Imported by axi4l2core and its testbench.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    WR_WAIT,
    RD_WAIT,
    B_RESP,
    R_RESP
  } axi4l2core_state_e;

endpackage

// File: rtl/axi4l2core_if.sv
// AXI4-Lite bus bundle: AW, W, B, AR, R channels.
// master drives addresses/data/readys of B,R; slave drives the rest.
interface axi4l2core_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4l2core_hold.sv
// Single-entry holding register: ready = !held, capture on valid&ready.
// Ports: valid_i/ready_o handshake, data_i/data_o payload, clr_i, held_o.
module axi4l2core_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         clr_i,
  output logic         held_o,
  output logic [W-1:0] data_o
);
  logic         held_q, held_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (clr_i) held_d = 1'b0;
    if (valid_i && !held_q) begin
      held_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

  assign ready_o = !held_q;
  assign held_o  = held_q;
  assign data_o  = data_q;
endmodule

// File: rtl/axi4l2core.sv
// AXI4-Lite slave to core req/gnt/rvalid bridge, one core access at a time.
// Ports: clk, rst_n, axi (slave), core req/gnt/we/be/addr/wdata_o/rvalid_i/rdata_i/err_i.
// Option AXI4L2CORE_ADDR_CHECK_EN: out-of-window addresses answer DECERR.
module axi4l2core
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] WINDOW_SIZE = 'h0001_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axi4l2core_if.slave             axi,
  output logic                    req,
  input  logic                    gnt,
  output logic                    we,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    err_i
);
  localparam int BW = DATA_WIDTH / 8;

  axi4l2core_state_e     state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  resp_t                 resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                     aw_held, w_held, ar_held;
  logic                     aw_clr, ar_clr;
  logic [ADDR_WIDTH-1:0]    aw_addr, ar_addr;
  logic [DATA_WIDTH+BW-1:0] w_pay;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [BW-1:0]            w_strb;
  logic                     aw_ok, ar_ok, wr_pick;
  logic                     unused_ok;

  axi4l2core_hold #(.W(ADDR_WIDTH)) u_aw (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (axi.awvalid),
    .ready_o (axi.awready),
    .data_i  (axi.awaddr),
    .clr_i   (aw_clr),
    .held_o  (aw_held),
    .data_o  (aw_addr)
  );

  axi4l2core_hold #(.W(DATA_WIDTH + BW)) u_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (axi.wvalid),
    .ready_o (axi.wready),
    .data_i  ({axi.wstrb, axi.wdata}),
    .clr_i   (aw_clr),
    .held_o  (w_held),
    .data_o  (w_pay)
  );

  axi4l2core_hold #(.W(ADDR_WIDTH)) u_ar (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (axi.arvalid),
    .ready_o (axi.arready),
    .data_i  (axi.araddr),
    .clr_i   (ar_clr),
    .held_o  (ar_held),
    .data_o  (ar_addr)
  );

  assign w_data = w_pay[DATA_WIDTH-1:0];
  assign w_strb = w_pay[DATA_WIDTH+BW-1:DATA_WIDTH];

`ifdef AXI4L2CORE_ADDR_CHECK_EN
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  // Unsigned offset compare also rejects addresses below the base.
  assign aw_off = aw_addr - BASE_ADDR;
  assign ar_off = ar_addr - BASE_ADDR;
  assign aw_ok  = aw_off < WINDOW_SIZE;
  assign ar_ok  = ar_off < WINDOW_SIZE;
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  // prot is not used; window params only matter with the check built in.
  assign unused_ok = ^{axi.awprot, axi.arprot, BASE_ADDR, WINDOW_SIZE};

  // Write wins unless a read also waits and the last served was a write.
  assign wr_pick = aw_held && w_held && (!ar_held || !last_wr_q);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    aw_clr    = 1'b0;
    ar_clr    = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    be        = '0;
    addr      = '0;
    wdata_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (wr_pick) begin
          if (aw_ok) begin
            state_d = WR_REQ;
          end else begin
            state_d = B_RESP;
            resp_d  = DECERR;
          end
        end else if (ar_held) begin
          if (ar_ok) begin
            state_d = RD_REQ;
          end else begin
            state_d = R_RESP;
            resp_d  = DECERR;
            rdata_d = '0;
          end
        end
      end
      WR_REQ: begin
        req     = 1'b1;
        we      = 1'b1;
        be      = w_strb;
        addr    = aw_addr;
        wdata_o = w_data;
        if (gnt) state_d = WR_WAIT;
      end
      RD_REQ: begin
        req  = 1'b1;
        be   = '1;
        addr = ar_addr;
        if (gnt) state_d = RD_WAIT;
      end
      WR_WAIT: begin
        if (rvalid_i) begin
          resp_d  = err_i ? SLVERR : OKAY;
          state_d = B_RESP;
        end
      end
      RD_WAIT: begin
        if (rvalid_i) begin
          resp_d  = err_i ? SLVERR : OKAY;
          rdata_d = rdata_i;
          state_d = R_RESP;
        end
      end
      B_RESP: begin
        if (axi.bready) begin
          aw_clr    = 1'b1;
          last_wr_d = 1'b1;
          state_d   = IDLE;
        end
      end
      R_RESP: begin
        if (axi.rready) begin
          ar_clr    = 1'b1;
          last_wr_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      resp_q    <= OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi.bvalid = (state_q == B_RESP);
  assign axi.bresp  = resp_q;
  assign axi.rvalid = (state_q == R_RESP);
  assign axi.rresp  = resp_q;
  assign axi.rdata  = rdata_q;
endmodule

// File: tb/tb_axi4l2core.sv
// Testbench for axi4l2core: AXI master tasks, behavioural core memory
// and shadow memory; randomized traffic plus directed scenarios.
module tb_axi4l2core;
  import axi4l_pkg::*;

`ifdef AXI4L2CORE_ADDR_CHECK_EN
  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] WIN  = 32'h1000;
`else
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] WIN  = 32'h1_0000;
`endif
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4l2core_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  logic        req, gnt, we, rvalid_i, err_i;
  logic [3:0]  be;
  logic [31:0] addr, wdata_o, rdata_i;

  axi4l2core #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .WINDOW_SIZE (WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axi      (axi),
    .req      (req),
    .gnt      (gnt),
    .we       (we),
    .be       (be),
    .addr     (addr),
    .wdata_o  (wdata_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .err_i    (err_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          c;
  } creq_t;

  creq_t       log_q[$];
  logic [31:0] mem    [1024];
  logic [31:0] shadow [1024];
  int          gnt_delay = 0;
  int          rsp_delay = 0;
  logic        err_next  = 1'b0;

  // Behavioural core: grant after gnt_delay cycles of req, answer
  // rsp_delay cycles later; keeps running across DUT resets.
  initial begin : core
    int   wcnt;
    int   left;
    bit   pend;
    logic [31:0] pd;
    logic pe;
    wcnt = 0; left = 0; pend = 0; pd = '0; pe = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    gnt = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    forever begin
      @(negedge clk);
      gnt = 1'b0;
      rvalid_i = 1'b0;
      if (pend) begin
        if (left == 0) begin
          rvalid_i = 1'b1; rdata_i = pd; err_i = pe; pend = 0;
        end else left--;
      end
      if (rst_n && req && !pend) begin
        if (wcnt < gnt_delay) wcnt++;
        else begin
          wcnt = 0;
          gnt = 1'b1;
          log_q.push_back('{we, addr, be, wdata_o, cyc});
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) mem[addr[11:2]][8*b +: 8] = wdata_o[8*b +: 8];
          end
          pd = we ? 32'h0 : mem[addr[11:2]];
          pe = err_next;
          pend = 1;
          left = rsp_delay;
        end
      end
    end
  end

  task automatic do_aw(input logic [31:0] a, output int hs);
    int n = 0;
    axi.awaddr = a; axi.awprot = 3'($urandom); axi.awvalid = 1'b1;
    while (!axi.awready && n < TMO) begin @(negedge clk); n++; end
    hs = cyc;
    if (n >= TMO) begin
      checks++; errors++; $display("FAIL aw_timeout awready=%b required 1", axi.awready);
    end
    @(negedge clk); axi.awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, output int hs);
    int n = 0;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    while (!axi.wready && n < TMO) begin @(negedge clk); n++; end
    hs = cyc;
    if (n >= TMO) begin
      checks++; errors++; $display("FAIL w_timeout wready=%b required 1", axi.wready);
    end
    @(negedge clk); axi.wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, output int hs);
    int n = 0;
    axi.araddr = a; axi.arprot = 3'($urandom); axi.arvalid = 1'b1;
    while (!axi.arready && n < TMO) begin @(negedge clk); n++; end
    hs = cyc;
    if (n >= TMO) begin
      checks++; errors++; $display("FAIL ar_timeout arready=%b required 1", axi.arready);
    end
    @(negedge clk); axi.arvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold, output logic [1:0] r, output int c);
    int n = 0;
    while (!axi.bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      checks++; errors++; $display("FAIL b_timeout bvalid=%b required 1", axi.bvalid);
    end
    c = cyc; r = axi.bresp;
    repeat (hold) @(negedge clk);
    axi.bready = 1'b1;
    @(negedge clk); axi.bready = 1'b0;
  endtask

  task automatic wait_r(input int hold, output logic [31:0] d,
                        output logic [1:0] r, output int c);
    int n = 0;
    while (!axi.rvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      checks++; errors++; $display("FAIL r_timeout rvalid=%b required 1", axi.rvalid);
    end
    c = cyc; d = axi.rdata; r = axi.rresp;
    repeat (hold) @(negedge clk);
    axi.rready = 1'b1;
    @(negedge clk); axi.rready = 1'b0;
  endtask

  function automatic void shadow_wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) shadow[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", axi.bvalid); end
    checks++; if (axi.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", axi.rvalid); end
    checks++; if ({req, we, be} !== 6'b0) begin errors++; $display("FAIL rst_req got %b want 0", {req, we, be}); end
    checks++; if ({addr, wdata_o} !== 64'h0) begin errors++; $display("FAIL rst_core got %h want 0", {addr, wdata_o}); end
    checks++; if ({axi.bresp, axi.rresp, axi.rdata} !== 36'h0) begin
      errors++; $display("FAIL rst_resp got %h want 0", {axi.bresp, axi.rresp, axi.rdata});
    end
    checks++; if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      errors++; $display("FAIL rst_ready got %b want 111", {axi.awready, axi.wready, axi.arready});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int ha, hw, cb, li;
    logic [1:0] r;
    logic [31:0] a = BASE + 32'h100;
    li = log_q.size();
    fork
      do_aw(a, ha);
      do_w(32'hDEAD_BEEF, 4'hF, hw);
    join
    wait_b(0, r, cb);
    shadow_wr(a, 32'hDEAD_BEEF, 4'hF);
    checks++; if (log_q.size() != li + 1) begin errors++; $display("FAIL wr_count got %0d want %0d", log_q.size(), li + 1); end
    if (log_q.size() > li) begin
      checks++; if ({log_q[li].we, log_q[li].addr, log_q[li].be, log_q[li].wdata} !== {1'b1, a, 4'hF, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL wr_core got %b %h %h %h want 1 %h f deadbeef",
          log_q[li].we, log_q[li].addr, log_q[li].be, log_q[li].wdata, a);
      end
      checks++; if (log_q[li].c - ha != 2) begin errors++; $display("FAIL wr_req_lat got %0d want 2", log_q[li].c - ha); end
    end
    checks++; if (cb - ha != 4) begin errors++; $display("FAIL wr_b_lat got %0d want 4", cb - ha); end
    checks++; if (r !== OKAY) begin errors++; $display("FAIL wr_bresp got %b want 00", r); end
  endtask

  task automatic test_w_before_aw();
    int ha, hw, cb, li, n0;
    logic [1:0] r;
    logic [31:0] a = BASE + 32'h208;
    li = log_q.size();
    do_w(32'hA5A5_0F0F, 4'b0101, hw);
    repeat (4) @(negedge clk);
    n0 = log_q.size();
    do_aw(a, ha);
    checks++; if (n0 != li) begin errors++; $display("FAIL wonly_req got %0d reqs want 0", n0 - li); end
    checks++; if (ha - hw != 5) begin errors++; $display("FAIL wonly_gap got %0d want 5", ha - hw); end
    wait_b(0, r, cb);
    shadow_wr(a, 32'hA5A5_0F0F, 4'b0101);
    repeat (3) @(negedge clk);
    checks++; if (log_q.size() != li + 1) begin errors++; $display("FAIL wonly_count got %0d want 1", log_q.size() - li); end
    if (log_q.size() > li) begin
      checks++; if (log_q[li].c < ha + 2) begin errors++; $display("FAIL wonly_early got cyc %0d want >= %0d", log_q[li].c, ha + 2); end
      checks++; if ({log_q[li].addr, log_q[li].be} !== {a, 4'b0101}) begin
        errors++; $display("FAIL wonly_core got %h %b want %h 0101", log_q[li].addr, log_q[li].be, a);
      end
    end
    checks++; if (axi.bvalid !== 1'b0 || r !== OKAY) begin
      errors++; $display("FAIL wonly_b got bvalid=%b resp=%b want 0 00", axi.bvalid, r);
    end
  endtask

  task automatic test_read_stall();
    int ha, hw, hr, cb, li, n;
    logic [1:0] r;
    logic [31:0] d;
    logic [31:0] a = BASE + 32'h40;
    fork
      do_aw(a, ha);
      do_w(32'h1234_5678, 4'hF, hw);
    join
    wait_b(0, r, cb);
    shadow_wr(a, 32'h1234_5678, 4'hF);
    gnt_delay = 3; err_next = 1'b1;
    li = log_q.size();
    do_ar(a, hr);
    n = 0;
    while (!axi.rvalid && n < TMO) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({axi.rvalid, axi.rdata, axi.rresp} !== {1'b1, shadow[a[11:2]], SLVERR}) begin
        errors++; $display("FAIL rd_hold got %b %h %b want 1 %h 10", axi.rvalid, axi.rdata, axi.rresp, shadow[a[11:2]]);
      end
      @(negedge clk);
    end
    wait_r(0, d, r, cb);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h want 12345678", d); end
    checks++; if (r !== SLVERR) begin errors++; $display("FAIL rd_resp got %b want 10", r); end
    checks++; if (log_q.size() != li + 1) begin errors++; $display("FAIL rd_count got %0d want 1", log_q.size() - li); end
    if (log_q.size() > li) begin
      checks++; if ({log_q[li].we, log_q[li].addr, log_q[li].be} !== {1'b0, a, 4'hF}) begin
        errors++; $display("FAIL rd_core got %b %h %h want 0 %h f", log_q[li].we, log_q[li].addr, log_q[li].be, a);
      end
      checks++; if (log_q[li].c - hr != 5) begin errors++; $display("FAIL rd_gnt_lat got %0d want 5", log_q[li].c - hr); end
    end
    gnt_delay = 0; err_next = 1'b0;
  endtask

  task automatic contest(input logic exp_wr_first, input string nm);
    int ha, hw, hr, cb, cr, li;
    logic [1:0] rb, rr;
    logic [31:0] d;
    logic [31:0] wa = BASE + 32'h300;
    logic [31:0] ra = BASE + 32'h100;
    logic [31:0] wd = $urandom;
    li = log_q.size();
    fork
      do_aw(wa, ha);
      do_w(wd, 4'hF, hw);
      do_ar(ra, hr);
    join
    fork
      wait_b(0, rb, cb);
      wait_r(0, d, rr, cr);
    join
    shadow_wr(wa, wd, 4'hF);
    checks++; if (log_q.size() != li + 2) begin errors++; $display("FAIL %s_count got %0d want 2", nm, log_q.size() - li); end
    if (log_q.size() > li + 1) begin
      checks++; if ({log_q[li].we, log_q[li + 1].we} !== {exp_wr_first, !exp_wr_first}) begin
        errors++; $display("FAIL %s_order got %b%b want %b%b", nm, log_q[li].we, log_q[li + 1].we, exp_wr_first, !exp_wr_first);
      end
    end
    checks++; if (d !== shadow[ra[11:2]] || rr !== OKAY || rb !== OKAY) begin
      errors++; $display("FAIL %s_data got %h %b %b want %h 00 00", nm, d, rr, rb, shadow[ra[11:2]]);
    end
  endtask

  task automatic test_contention();
    int ha, hw, cb;
    logic [1:0] r;
    do_reset();
    contest(1'b1, "cont_a");
    fork
      do_aw(BASE + 32'h10, ha);
      do_w(32'h0, 4'h0, hw);
    join
    wait_b(0, r, cb);
    contest(1'b0, "cont_b");
  endtask

  task automatic test_backpressure_reset();
    int ha, hw, hr, li, n;
    logic [1:0] r;
    logic [31:0] a = BASE + 32'h80;
    logic [31:0] wd = $urandom;
    err_next = 1'b1;
    fork
      do_aw(a, ha);
      do_w(wd, 4'hF, hw);
    join
    n = 0;
    while (!axi.bvalid && n < TMO) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++; if ({axi.bvalid, axi.bresp} !== {1'b1, SLVERR}) begin
        errors++; $display("FAIL bp_hold cycle %0d got %b %b want 1 10", i, axi.bvalid, axi.bresp);
      end
      @(negedge clk);
    end
    wait_b(0, r, n);
    shadow_wr(a, wd, 4'hF);
    err_next = 1'b0;
    rsp_delay = 5;
    li = log_q.size();
    do_ar(a, hr);
    n = 0;
    while (log_q.size() == li && n < TMO) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({req, axi.rvalid} !== 2'b00) begin errors++; $display("FAIL rst_mid got req=%b rvalid=%b want 0 0", req, axi.rvalid); end
    checks++; if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      errors++; $display("FAIL rst_mid_ready got %b want 111", {axi.awready, axi.wready, axi.arready});
    end
    @(negedge clk); rst_n = 1'b1;
    li = log_q.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if ({axi.rvalid, axi.bvalid, req} !== 3'b000) begin
        errors++; $display("FAIL late_rsp cycle %0d got rvalid=%b bvalid=%b req=%b want 000", i, axi.rvalid, axi.bvalid, req);
      end
    end
    checks++; if (log_q.size() != li) begin errors++; $display("FAIL late_req got %0d want 0", log_q.size() - li); end
    rsp_delay = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int ha, hw, hr, c, li, da, dw;
      logic [1:0] r;
      logic [31:0] d;
      logic [31:0] a = BASE + ($urandom_range(0, 1023) << 2);
      logic [31:0] wd = $urandom;
      logic [3:0] s = 4'($urandom);
      logic e = 1'($urandom);
      bit is_wr = 1'($urandom);
      gnt_delay = $urandom_range(0, 3);
      rsp_delay = $urandom_range(0, 2);
      err_next = e;
      da = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      li = log_q.size();
      if (is_wr) begin
        fork
          begin repeat (da) @(negedge clk); do_aw(a, ha); end
          begin repeat (dw) @(negedge clk); do_w(wd, s, hw); end
        join
        wait_b($urandom_range(0, 3), r, c);
        shadow_wr(a, wd, s);
        checks++; if (r !== (e ? SLVERR : OKAY)) begin errors++; $display("FAIL rnd_bresp t=%0d got %b want %b", t, r, e ? SLVERR : OKAY); end
        if (log_q.size() == li + 1) begin
          checks++; if ({log_q[li].we, log_q[li].addr, log_q[li].be, log_q[li].wdata} !== {1'b1, a, s, wd}) begin
            errors++; $display("FAIL rnd_wcore t=%0d got %b %h %h %h want 1 %h %h %h",
              t, log_q[li].we, log_q[li].addr, log_q[li].be, log_q[li].wdata, a, s, wd);
          end
        end
      end else begin
        do_ar(a, hr);
        wait_r($urandom_range(0, 3), d, r, c);
        checks++; if ({d, r} !== {shadow[a[11:2]], (e ? SLVERR : OKAY)}) begin
          errors++; $display("FAIL rnd_read t=%0d got %h %b want %h %b", t, d, r, shadow[a[11:2]], e ? SLVERR : OKAY);
        end
        if (log_q.size() == li + 1) begin
          checks++; if ({log_q[li].we, log_q[li].addr, log_q[li].be} !== {1'b0, a, 4'hF}) begin
            errors++; $display("FAIL rnd_rcore t=%0d got %b %h %h want 0 %h f", t, log_q[li].we, log_q[li].addr, log_q[li].be, a);
          end
        end
      end
      checks++; if (log_q.size() != li + 1) begin errors++; $display("FAIL rnd_count t=%0d got %0d want 1", t, log_q.size() - li); end
    end
    gnt_delay = 0; rsp_delay = 0; err_next = 1'b0;
  endtask

`ifdef AXI4L2CORE_ADDR_CHECK_EN
  task automatic test_addr_check();
    int hr, c, li;
    logic [1:0] r;
    logic [31:0] d;
    li = log_q.size();
    do_ar(32'h2000, hr);
    wait_r(0, d, r, c);
    checks++; if ({d, r} !== {32'h0, DECERR}) begin errors++; $display("FAIL win_out got %h %b want 0 11", d, r); end
    checks++; if (log_q.size() != li) begin errors++; $display("FAIL win_out_req got %0d want 0", log_q.size() - li); end
    do_ar(32'h1FFC, hr);
    wait_r(0, d, r, c);
    checks++; if ({d, r} !== {shadow[10'h3FF], OKAY}) begin errors++; $display("FAIL win_in got %h %b want %h 00", d, r, shadow[10'h3FF]); end
    checks++; if (log_q.size() != li + 1) begin errors++; $display("FAIL win_in_req got %0d want 1", log_q.size() - li); end
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    foreach (shadow[i]) shadow[i] = '0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.bready = 1'b0; axi.rready = 1'b0;
    test_reset();
    test_write();
    test_w_before_aw();
    test_read_stall();
    test_contention();
    test_backpressure_reset();
    test_random();
`ifdef AXI4L2CORE_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4l2core.md
Name: axi4l2core

Overview:
- AXI4-Lite slave that converts bus transactions into core-style memory requests (req/gnt/rvalid), the inverse direction of the core2axi4l bridge.
- Lets an AXI4-Lite master (e.g. a debug/DMA master on the interconnect) access core-side memories and peripherals.
- One transaction outstanding on the core side at a time. Independent AW/W/AR holding registers decouple the AXI channels.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr/addr
- DATA_WIDTH, 32, width of data buses; strobe/be width is DATA_WIDTH/8
- BASE_ADDR, 32'h0000_0000, start of decoded window (used only with AXI4L2CORE_ADDR_CHECK_EN)
- WINDOW_SIZE, 32'h0001_0000, window size in bytes, power of two (used only with AXI4L2CORE_ADDR_CHECK_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- awaddr, awprot, awvalid, awready  in/in/in/out  ADDR_WIDTH/3/1/1  AXI write address; awprot ignored
- wdata, wstrb, wvalid, wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data
- bresp, bvalid, bready  out/out/in  2/1/1  AXI write response
- araddr, arprot, arvalid, arready  in/in/in/out  ADDR_WIDTH/3/1/1  AXI read address; arprot ignored
- rdata, rresp, rvalid, rready  out/out/out/in  DATA_WIDTH/2/1/1  AXI read data
- req, gnt  out/in  1/1  core request and grant
- we  out  1  core write enable
- be  out  DATA_WIDTH/8  core byte enables
- addr  out  ADDR_WIDTH  core address
- wdata_o  out  DATA_WIDTH  core write data
- rvalid_i  in  1  core response valid
- rdata_i  in  DATA_WIDTH  core read data
- err_i  in  1  core response error

Behaviour:
- Holding registers for AW, W and AR, each with a held flag; all flags reset to 0.
  - awready = !aw_held, wready = !w_held, arready = !ar_held.
  - Readys are therefore 1 after reset; AXI requires only valids to be low during reset.
  - A handshake captures the payload and sets the flag on the next edge.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_WAIT, RD_WAIT, B_RESP, R_RESP. Reset state is IDLE.
- IDLE:
  - Write is eligible when aw_held && w_held; read is eligible when ar_held.
  - If both are eligible, serve the direction not served last; last_wr resets to 0, so write wins the first contest.
  - Eligible write -> WR_REQ; eligible read -> RD_REQ.
- WR_REQ / RD_REQ:
  - req=1; addr, we, be, wdata_o driven from the holding registers and stable until gnt.
  - Reads drive be all-ones.
  - gnt -> WR_WAIT / RD_WAIT.
- WR_WAIT / RD_WAIT:
  - Wait for rvalid_i, which arrives at the earliest one cycle after gnt.
  - On rvalid_i, register the response code: OKAY=2'b00 if !err_i, else SLVERR=2'b10.
  - In RD_WAIT, also register rdata_i.
  - Then -> B_RESP / R_RESP.
- B_RESP:
  - bvalid=1, bresp held.
  - On bready, clear aw_held and w_held, set last_wr=1 -> IDLE.
- R_RESP:
  - rvalid=1, rdata/rresp held.
  - On rready, clear ar_held, set last_wr=0 -> IDLE.
- rvalid_i outside the WAIT states is ignored.
- Latency, zero-wait core (gnt in the req cycle, rvalid_i on the next cycle):
  - AW/W handshake at cycle N -> req at N+2 -> bvalid at N+4.
  - AR behaves the same way with rvalid.
- AW and W may arrive in any order or cycle. A W-only transfer waits indefinitely and never issues a core request.
- New AW/W/AR may be captured while the other direction is in flight. They are served only after return to IDLE.
- Reset values: bvalid=0, rvalid=0, req=0, we=0, bresp=0, rresp=0, rdata=0, addr=0, be=0, wdata_o=0.
- Reset mid-operation:
  - Everything clears asynchronously and req drops immediately.
  - A late rvalid_i after reset is ignored, since the FSM is in IDLE.

Optional Feature:
- Macro: AXI4L2CORE_ADDR_CHECK_EN.
- Defined: in IDLE, an address outside [BASE_ADDR, BASE_ADDR+WINDOW_SIZE) issues no core request.
  - FSM goes directly to B_RESP/R_RESP with resp DECERR=2'b11 and rdata=0.
  - Arbitration is unchanged.
- Not defined: every address is forwarded and BASE_ADDR/WINDOW_SIZE are unused.

Decomposition:
- axi4l_pkg supplies the resp_t enum (OKAY, EXOKAY, SLVERR, DECERR); add the FSM state enum type axi4l2core_state_e there.
- Sub-module axi4l2core_hold: a parameterised single-entry holding register (valid/ready in, payload, held flag, clear). Instantiated three times for AW, W and AR.

Test Plan:
- Write: AW addr=0x100 and W data=0xDEADBEEF, strb=0xF in the same cycle; gnt immediate, rvalid_i next cycle -> core sees addr=0x100, we=1, be=0xF, wdata_o=0xDEADBEEF; bvalid 4 cycles after the handshake with bresp=OKAY.
- Write, W before AW: W at cycle 0, AW at cycle 5 -> no req before cycle 7; single core write; one B response.
- Read with a stalling grant: AR addr=0x40; gnt after 3 cycles; rdata_i=0x12345678 with err_i=1 -> rdata=0x12345678, rresp=SLVERR, held until rready.
- Contention: AR and AW+W all held simultaneously after reset -> write served first, then read. Repeating the contest gives read first.
- Backpressure and reset: bready held low 10 cycles -> bvalid/bresp stable. Reset asserted in RD_WAIT -> req=0, rvalid=0, all readys 1. A later rvalid_i is ignored.
- With AXI4L2CORE_ADDR_CHECK_EN, BASE_ADDR=0x1000, WINDOW_SIZE=0x1000: read of 0x2000 -> no req, rresp=DECERR, rdata=0. Read of 0x1FFC -> forwarded to the core.
